// File: rtl/pipebomb_tob_publisher_if.sv
// Top-of-book message stream: one sequenced TOB message per valid/ready handshake.
interface pipebomb_tob_publisher_if #(
    parameter int unsigned N_SYM   = 4,
    parameter int unsigned PRICE_W = 48,
    parameter int unsigned SEQ_W   = 32
);
    localparam int unsigned SYM_W = $clog2(N_SYM);

    logic               out_v;
    logic               out_r;
    logic [SYM_W-1:0]   out_sym;
    logic [PRICE_W-1:0] out_bid;
    logic [PRICE_W-1:0] out_ask;
    logic               out_bid_v;
    logic               out_ask_v;
    logic [PRICE_W-1:0] out_spread;
    logic               out_crossed;
    logic [SEQ_W-1:0]   out_seq;

    modport master (
        output out_v, out_sym, out_bid, out_ask, out_bid_v, out_ask_v,
               out_spread, out_crossed, out_seq,
        input  out_r
    );

    modport slave (
        input  out_v, out_sym, out_bid, out_ask, out_bid_v, out_ask_v,
               out_spread, out_crossed, out_seq,
        output out_r
    );
endinterface

// File: rtl/pipebomb_tob_publisher.sv
// Multi-symbol top-of-book publisher: snapshots per-symbol best bid/ask, coalesces
// level changes per symbol and emits change-only, sequenced messages round-robin.
module pipebomb_tob_publisher #(
    parameter int unsigned N_SYM   = 4,
    parameter int unsigned PRICE_W = 48,
    parameter int unsigned SEQ_W   = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N_SYM*PRICE_W-1:0]   in_bid_price,
    input  logic [N_SYM*PRICE_W-1:0]   in_ask_price,
    input  logic [N_SYM-1:0]           in_bid_v,
    input  logic [N_SYM-1:0]           in_ask_v,
    input  logic                       publish_all,
    pipebomb_tob_publisher_if.master   tob,
    output logic                       crossed_sticky,
    output logic [CNT_W-1:0]           coalesced_cnt
);
    localparam int unsigned SYM_W = $clog2(N_SYM);
    localparam int unsigned POP_W = $clog2(N_SYM + 1);
    localparam int unsigned SAT_W = CNT_W + POP_W;
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

    typedef struct packed {
        logic               bid_v;
        logic [PRICE_W-1:0] bid;
        logic               ask_v;
        logic [PRICE_W-1:0] ask;
    } key_t;

    key_t               key_in [N_SYM];
    key_t               snap_q [N_SYM];
    logic [N_SYM-1:0]   chg;
    logic [N_SYM-1:0]   pending_q, pending_d;
    logic [SYM_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sticky_q, sticky_d;

    logic               out_v_q, out_v_d;
    logic [SYM_W-1:0]   out_sym_q, out_sym_d;
    logic [PRICE_W-1:0] out_bid_q, out_bid_d;
    logic [PRICE_W-1:0] out_ask_q, out_ask_d;
    logic               out_bid_v_q, out_bid_v_d;
    logic               out_ask_v_q, out_ask_v_d;
    logic [PRICE_W-1:0] out_spread_q, out_spread_d;
    logic               out_crossed_q, out_crossed_d;
    logic [SEQ_W-1:0]   out_seq_q, out_seq_d;

    logic               gnt_found;
    logic [SYM_W-1:0]   gnt_idx;
    logic               load_c;
    logic [N_SYM-1:0]   gnt_oh;
    logic [POP_W-1:0]   coal_pop;
    logic [SAT_W-1:0]   cnt_sum;
    key_t               sel;
    logic               sel_crossed;

    // Input key with invalid-side prices forced to zero, and per-symbol change detect
    always_comb begin
        for (int unsigned s = 0; s < N_SYM; s++) begin
            key_in[s].bid_v = in_bid_v[s];
            key_in[s].bid   = in_bid_v[s] ? in_bid_price[s*PRICE_W +: PRICE_W] : '0;
            key_in[s].ask_v = in_ask_v[s];
            key_in[s].ask   = in_ask_v[s] ? in_ask_price[s*PRICE_W +: PRICE_W] : '0;
            chg[s]          = (key_in[s] != snap_q[s]);
        end
    end

    // Round-robin search for the first pending symbol at or above rr_ptr
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < N_SYM; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= N_SYM) begin
                idx = idx - N_SYM;
            end
            if (!gnt_found && pending_q[SYM_W'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = SYM_W'(idx);
            end
        end
    end

    assign load_c      = (!out_v_q || tob.out_r) && gnt_found;
    assign gnt_oh      = load_c ? (N_SYM'(1) << gnt_idx) : '0;
    assign sel         = snap_q[gnt_idx];
    assign sel_crossed = sel.bid_v && sel.ask_v && (sel.bid >= sel.ask);

    // Next-state for pending set, coalesce counter and output message register
    always_comb begin
        pending_d     = pending_q;
        rr_ptr_d      = rr_ptr_q;
        seq_d         = seq_q;
        sticky_d      = sticky_q;
        out_v_d       = out_v_q;
        out_sym_d     = out_sym_q;
        out_bid_d     = out_bid_q;
        out_ask_d     = out_ask_q;
        out_bid_v_d   = out_bid_v_q;
        out_ask_v_d   = out_ask_v_q;
        out_spread_d  = out_spread_q;
        out_crossed_d = out_crossed_q;
        out_seq_d     = out_seq_q;
        coal_pop      = '0;

        for (int unsigned s = 0; s < N_SYM; s++) begin
            // A grant in the same cycle as a change loaded the stale snapshot, so keep it pending
            pending_d[s] = chg[s] || publish_all || (pending_q[s] && !gnt_oh[s]);
            coal_pop     = coal_pop + POP_W'(chg[s] && pending_q[s] && !gnt_oh[s]);
        end

        if (load_c) begin
            out_v_d       = 1'b1;
            out_sym_d     = gnt_idx;
            out_bid_v_d   = sel.bid_v;
            out_ask_v_d   = sel.ask_v;
            out_bid_d     = sel.bid;
            out_ask_d     = sel.ask;
            out_crossed_d = sel_crossed;
            out_spread_d  = (sel.bid_v && sel.ask_v && !sel_crossed) ? (sel.ask - sel.bid) : '0;
            out_seq_d     = seq_q;
            seq_d         = seq_q + SEQ_W'(1);
            rr_ptr_d      = (gnt_idx == SYM_W'(N_SYM - 1)) ? '0 : gnt_idx + SYM_W'(1);
            if (sel_crossed) begin
                sticky_d = 1'b1;
            end
        end else if (out_v_q && tob.out_r) begin
            out_v_d = 1'b0;
        end

        cnt_sum = SAT_W'(cnt_q) + SAT_W'(coal_pop);
        cnt_d   = (cnt_sum > CNT_MAX) ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned s = 0; s < N_SYM; s++) begin
                snap_q[s] <= '0;
            end
            pending_q     <= '0;
            rr_ptr_q      <= '0;
            seq_q         <= '0;
            cnt_q         <= '0;
            sticky_q      <= 1'b0;
            out_v_q       <= 1'b0;
            out_sym_q     <= '0;
            out_bid_q     <= '0;
            out_ask_q     <= '0;
            out_bid_v_q   <= 1'b0;
            out_ask_v_q   <= 1'b0;
            out_spread_q  <= '0;
            out_crossed_q <= 1'b0;
            out_seq_q     <= '0;
        end else begin
            for (int unsigned s = 0; s < N_SYM; s++) begin
                snap_q[s] <= key_in[s];
            end
            pending_q     <= pending_d;
            rr_ptr_q      <= rr_ptr_d;
            seq_q         <= seq_d;
            cnt_q         <= cnt_d;
            sticky_q      <= sticky_d;
            out_v_q       <= out_v_d;
            out_sym_q     <= out_sym_d;
            out_bid_q     <= out_bid_d;
            out_ask_q     <= out_ask_d;
            out_bid_v_q   <= out_bid_v_d;
            out_ask_v_q   <= out_ask_v_d;
            out_spread_q  <= out_spread_d;
            out_crossed_q <= out_crossed_d;
            out_seq_q     <= out_seq_d;
        end
    end

    assign tob.out_v       = out_v_q;
    assign tob.out_sym     = out_sym_q;
    assign tob.out_bid     = out_bid_q;
    assign tob.out_ask     = out_ask_q;
    assign tob.out_bid_v   = out_bid_v_q;
    assign tob.out_ask_v   = out_ask_v_q;
    assign tob.out_spread  = out_spread_q;
    assign tob.out_crossed = out_crossed_q;
    assign tob.out_seq     = out_seq_q;
    assign crossed_sticky  = sticky_q;
    assign coalesced_cnt   = cnt_q;
endmodule

// File: tb/tb_pipebomb_tob_publisher.sv
// Directed and randomized bench for the top-of-book publisher against a
// per-cycle message model built from the publishing rules.
module tb_pipebomb_tob_publisher;
    localparam int unsigned N_SYM   = 4;
    localparam int unsigned PRICE_W = 48;
    localparam int unsigned SEQ_W   = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int          CNT_SAT = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [N_SYM*PRICE_W-1:0] in_bid_price;
    logic [N_SYM*PRICE_W-1:0] in_ask_price;
    logic [N_SYM-1:0]         in_bid_v;
    logic [N_SYM-1:0]         in_ask_v;
    logic                     publish_all;
    logic                     crossed_sticky;
    logic [CNT_W-1:0]         coalesced_cnt;

    pipebomb_tob_publisher_if #(.N_SYM(N_SYM), .PRICE_W(PRICE_W), .SEQ_W(SEQ_W)) tob_if ();

    pipebomb_tob_publisher #(
        .N_SYM(N_SYM), .PRICE_W(PRICE_W), .SEQ_W(SEQ_W), .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_bid_price   (in_bid_price),
        .in_ask_price   (in_ask_price),
        .in_bid_v       (in_bid_v),
        .in_ask_v       (in_ask_v),
        .publish_all    (publish_all),
        .tob            (tob_if),
        .crossed_sticky (crossed_sticky),
        .coalesced_cnt  (coalesced_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what the publisher last saw per symbol, what it still owes, and the message on the wire
    logic               m_bv [N_SYM];
    logic               m_av [N_SYM];
    logic [PRICE_W-1:0] m_b  [N_SYM];
    logic [PRICE_W-1:0] m_a  [N_SYM];
    bit                 m_pend [N_SYM];
    int                 m_rr;
    logic [SEQ_W-1:0]   m_seq;
    int                 m_cnt;
    bit                 m_sticky;
    bit                 m_out_v;
    int                 m_out_sym;
    logic [PRICE_W-1:0] m_out_bid, m_out_ask, m_out_spread;
    bit                 m_out_bid_v, m_out_ask_v, m_out_crossed;
    logic [SEQ_W-1:0]   m_out_seq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < N_SYM; s++) begin
            m_bv[s] = 0; m_av[s] = 0; m_b[s] = '0; m_a[s] = '0; m_pend[s] = 0;
        end
        m_rr = 0; m_seq = '0; m_cnt = 0; m_sticky = 0;
        m_out_v = 0; m_out_sym = 0; m_out_bid = '0; m_out_ask = '0; m_out_spread = '0;
        m_out_bid_v = 0; m_out_ask_v = 0; m_out_crossed = 0; m_out_seq = '0;
    endtask

    // Advance the reference by one clock using the inputs currently applied
    task automatic model_clock();
        bit                 chg [N_SYM];
        logic               nbv, nav;
        logic [PRICE_W-1:0] nb, na;
        int                 g;
        g = -1;
        if (!m_out_v || tob_if.out_r) begin
            for (int k = 0; k < N_SYM; k++) begin
                int s;
                s = (m_rr + k) % N_SYM;
                if (g < 0 && m_pend[s]) g = s;
            end
        end
        if (g >= 0) begin
            m_out_v       = 1;
            m_out_sym     = g;
            m_out_bid_v   = m_bv[g];
            m_out_ask_v   = m_av[g];
            m_out_bid     = m_b[g];
            m_out_ask     = m_a[g];
            m_out_crossed = m_bv[g] && m_av[g] && (m_b[g] >= m_a[g]);
            m_out_spread  = (m_bv[g] && m_av[g] && m_b[g] < m_a[g]) ? m_a[g] - m_b[g] : '0;
            m_out_seq     = m_seq;
            m_seq         = m_seq + 1;
            m_rr          = (g + 1) % N_SYM;
            if (m_out_crossed) m_sticky = 1;
        end else if (m_out_v && tob_if.out_r) begin
            m_out_v = 0;
        end
        for (int s = 0; s < N_SYM; s++) begin
            nbv = in_bid_v[s];
            nav = in_ask_v[s];
            nb  = nbv ? in_bid_price[s*PRICE_W +: PRICE_W] : '0;
            na  = nav ? in_ask_price[s*PRICE_W +: PRICE_W] : '0;
            chg[s] = (nbv != m_bv[s]) || (nav != m_av[s]) || (nb != m_b[s]) || (na != m_a[s]);
            if (chg[s] && m_pend[s] && s != g && m_cnt < CNT_SAT) m_cnt++;
            m_pend[s] = chg[s] || publish_all || (m_pend[s] && s != g);
            m_bv[s] = nbv; m_av[s] = nav; m_b[s] = nb; m_a[s] = na;
        end
    endtask

    // One clock: advance model, then compare every visible output
    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        chk("out_v", 64'(tob_if.out_v), 64'(m_out_v));
        if (m_out_v) begin
            chk("out_sym", 64'(tob_if.out_sym), 64'(m_out_sym));
            chk("out_bid", 64'(tob_if.out_bid), 64'(m_out_bid));
            chk("out_ask", 64'(tob_if.out_ask), 64'(m_out_ask));
            chk("out_bid_v", 64'(tob_if.out_bid_v), 64'(m_out_bid_v));
            chk("out_ask_v", 64'(tob_if.out_ask_v), 64'(m_out_ask_v));
            chk("out_spread", 64'(tob_if.out_spread), 64'(m_out_spread));
            chk("out_crossed", 64'(tob_if.out_crossed), 64'(m_out_crossed));
            chk("out_seq", 64'(tob_if.out_seq), 64'(m_out_seq));
        end
        chk("coalesced_cnt", 64'(coalesced_cnt), 64'(m_cnt));
        chk("crossed_sticky", 64'(crossed_sticky), 64'(m_sticky));
    endtask

    task automatic set_sym(input int s, input logic bv, input logic [PRICE_W-1:0] b,
                           input logic av, input logic [PRICE_W-1:0] a);
        in_bid_v[s] = bv;
        in_ask_v[s] = av;
        in_bid_price[s*PRICE_W +: PRICE_W] = b;
        in_ask_price[s*PRICE_W +: PRICE_W] = a;
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        in_bid_price = '0;
        in_ask_price = '0;
        in_bid_v     = '0;
        in_ask_v     = '0;
        publish_all  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        rstn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tob_if.out_r = 1'b1;
        do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_out_v", 64'(tob_if.out_v), 64'd0);
        chk("rst_out_seq", 64'(tob_if.out_seq), 64'd0);
        chk("rst_cnt", 64'(coalesced_cnt), 64'd0);
        chk("rst_sticky", 64'(crossed_sticky), 64'd0);
        rstn = 1'b1;

        // Idle after reset with all levels invalid
        for (int i = 0; i < 20; i++) step();
        chk("idle_out_v", 64'(tob_if.out_v), 64'd0);
        chk("idle_seq", 64'(tob_if.out_seq), 64'd0);
        chk("idle_cnt", 64'(coalesced_cnt), 64'd0);

        // Single change, two-cycle latency, exactly one message
        set_sym(2, 1'b1, 48'd1000, 1'b1, 48'd1010);
        step();
        chk("lat_early", 64'(tob_if.out_v), 64'd0);
        step();
        chk("lat_v", 64'(tob_if.out_v), 64'd1);
        chk("lat_sym", 64'(tob_if.out_sym), 64'd2);
        chk("lat_bid", 64'(tob_if.out_bid), 64'd1000);
        chk("lat_ask", 64'(tob_if.out_ask), 64'd1010);
        chk("lat_spread", 64'(tob_if.out_spread), 64'd10);
        chk("lat_crossed", 64'(tob_if.out_crossed), 64'd0);
        chk("lat_seq", 64'(tob_if.out_seq), 64'd0);
        step();
        chk("lat_once", 64'(tob_if.out_v), 64'd0);
        for (int i = 0; i < 4; i++) step();
        chk("lat_once_late", 64'(tob_if.out_v), 64'd0);

        // Coalescing under backpressure
        do_reset();
        tob_if.out_r = 1'b0;
        set_sym(1, 1'b1, 48'd100, 1'b0, 48'd0);
        for (int i = 0; i < 6 && !tob_if.out_v; i++) step();
        chk("coal_v", 64'(tob_if.out_v), 64'd1);
        chk("coal_bid0", 64'(tob_if.out_bid), 64'd100);
        set_sym(1, 1'b1, 48'd101, 1'b0, 48'd0);
        step();
        set_sym(1, 1'b1, 48'd102, 1'b0, 48'd0);
        step();
        chk("coal_cnt", 64'(coalesced_cnt), 64'd1);
        chk("coal_hold_bid", 64'(tob_if.out_bid), 64'd100);
        chk("coal_hold_seq", 64'(tob_if.out_seq), 64'd0);
        tob_if.out_r = 1'b1;
        step();
        chk("coal_bid1", 64'(tob_if.out_bid), 64'd102);
        chk("coal_seq1", 64'(tob_if.out_seq), 64'd1);
        step();
        chk("coal_done", 64'(tob_if.out_v), 64'd0);

        // All symbols change together, then round-robin from rr_ptr
        do_reset();
        for (int s = 0; s < N_SYM; s++) set_sym(s, 1'b1, 48'(200 + s), 1'b1, 48'(300 + s));
        step();
        for (int s = 0; s < N_SYM; s++) begin
            step();
            chk("rr_sym", 64'(tob_if.out_sym), 64'(s));
            chk("rr_seq", 64'(tob_if.out_seq), 64'(s));
        end
        step();
        chk("rr_idle", 64'(tob_if.out_v), 64'd0);
        set_sym(0, 1'b1, 48'd210, 1'b1, 48'd300);
        set_sym(3, 1'b1, 48'd213, 1'b1, 48'd303);
        step();
        step();
        chk("rr2_sym0", 64'(tob_if.out_sym), 64'd0);
        chk("rr2_seq4", 64'(tob_if.out_seq), 64'd4);
        step();
        chk("rr2_sym3", 64'(tob_if.out_sym), 64'd3);
        chk("rr2_seq5", 64'(tob_if.out_seq), 64'd5);

        // Crossed book and sticky flag
        do_reset();
        set_sym(0, 1'b1, 48'd1010, 1'b1, 48'd1010);
        step(); step();
        chk("x_crossed", 64'(tob_if.out_crossed), 64'd1);
        chk("x_spread", 64'(tob_if.out_spread), 64'd0);
        chk("x_sticky", 64'(crossed_sticky), 64'd1);
        set_sym(0, 1'b1, 48'd1000, 1'b1, 48'd1010);
        step(); step();
        chk("x2_crossed", 64'(tob_if.out_crossed), 64'd0);
        chk("x2_spread", 64'(tob_if.out_spread), 64'd10);
        chk("x2_sticky", 64'(crossed_sticky), 64'd1);

        // Asynchronous reset with a stalled message, then publish_all
        do_reset();
        tob_if.out_r = 1'b0;
        set_sym(2, 1'b1, 48'd500, 1'b1, 48'd510);
        set_sym(1, 1'b1, 48'd400, 1'b0, 48'd0);
        step(); step();
        chk("ar_v_before", 64'(tob_if.out_v), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_v_async", 64'(tob_if.out_v), 64'd0);
        model_reset();
        in_bid_v = '0; in_ask_v = '0; in_bid_price = '0; in_ask_price = '0;
        tob_if.out_r = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("ar_pend_clr", 64'(tob_if.out_v), 64'd0);
        publish_all = 1'b1;
        step();
        publish_all = 1'b0;
        for (int s = 0; s < N_SYM; s++) begin
            step();
            chk("pa_sym", 64'(tob_if.out_sym), 64'(s));
            chk("pa_seq", 64'(tob_if.out_seq), 64'(s));
            chk("pa_bid_v", 64'(tob_if.out_bid_v), 64'd0);
        end
        step();
        chk("pa_done", 64'(tob_if.out_v), 64'd0);

        // Randomized traffic: sparse level changes, random backpressure, occasional publish_all
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            for (int s = 0; s < N_SYM; s++) begin
                if ($urandom_range(0, 3) == 0) begin
                    set_sym(s, 1'($urandom_range(0, 3) != 0), 48'(990 + $urandom_range(0, 30)),
                               1'($urandom_range(0, 3) != 0), 48'(995 + $urandom_range(0, 30)));
                end
            end
            tob_if.out_r = 1'($urandom_range(0, 3) != 0);
            publish_all  = 1'($urandom_range(0, 49) == 0);
            step();
        end
        publish_all  = 1'b0;
        tob_if.out_r = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("rand_drain", 64'(tob_if.out_v), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipebomb_tob_publisher.md
Name: pipebomb_tob_publisher

Overview:
Multi-symbol top-of-book publisher. It samples per-symbol best bid/ask from N_SYM price-cache pairs, detects level changes, and coalesces them per symbol. It emits sequenced, change-only TOB messages on one valid/ready stream, using round-robin fairness. It sits after the per-symbol price caches and replaces the single registered best_bid/best_ask/best_valid output stage.

Parameters:
N_SYM, 4, number of symbols/books (>=2); SYM_W = $clog2(N_SYM), derived.
PRICE_W, 48, price width.
SEQ_W, 32, message sequence number width.
CNT_W, 16, coalesce counter width.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_bid_price  in  N_SYM*PRICE_W  best bid per symbol, symbol s at [s*PRICE_W +: PRICE_W]
in_ask_price  in  N_SYM*PRICE_W  best ask per symbol, same packing
in_bid_v  in  N_SYM  bid level valid per symbol
in_ask_v  in  N_SYM  ask level valid per symbol
publish_all  in  1  pulse: force a message for every symbol
out_v  out  1  message valid
out_r  in  1  message ready
out_sym  out  SYM_W  symbol index
out_bid  out  PRICE_W  bid price (0 if !out_bid_v)
out_ask  out  PRICE_W  ask price (0 if !out_ask_v)
out_bid_v  out  1  bid valid
out_ask_v  out  1  ask valid
out_spread  out  PRICE_W  ask-bid if both valid and not crossed, else 0
out_crossed  out  1  both valid and bid >= ask
out_seq  out  SEQ_W  global message sequence number
crossed_sticky  out  1  set on any emitted crossed message
coalesced_cnt  out  CNT_W  saturating count of overwritten unsent updates

Behaviour:
- Reset (rstn low, async): all outputs 0; snapshot regs 0; pending 0; rr_ptr 0; seq counter 0. An in-flight message is dropped.
- Key per symbol s: {bid_v, bid_v?bid:0, ask_v, ask_v?ask:0}. Price bits of an invalid side are ignored.
- Snapshot snap[s] registers the input key every cycle, unconditionally.
- chg[s] = (input key != snap[s]) in the current cycle.
- pending[s] next value:
  - set if chg[s] or publish_all;
  - else cleared if s is granted this cycle;
  - else held.
  - chg and grant in the same cycle leave pending set: the grant loaded the stale snapshot.
- Load condition: (!out_v || out_r) && |pending.
  - Grant = first pending symbol searching upward from rr_ptr, wrapping at N_SYM-1 to 0.
  - The output register loads from snap[grant].
  - rr_ptr becomes (grant+1) mod N_SYM.
  - out_seq gets the seq counter value; the counter then increments and wraps at 2^SEQ_W.
  - out_crossed and out_spread are computed at load from snap values, unsigned.
- If out_v && !out_r, all out_* fields are held stable; no other change. If out_v && out_r and nothing is pending, out_v drops next cycle.
- Throughput: one message per cycle while out_r=1 and updates are pending.
- Latency: an input change at cycle t raises out_v at t+2 when the output stage is idle.
- Coalesce: coalesced_cnt += popcount over s of (chg[s] && pending[s] && !granted[s]), saturating at 2^CNT_W-1.
- crossed_sticky sets at the load of any crossed message and clears only on reset.
- publish_all with some pending already set: no duplicates; one message per symbol.
- After reset with all inputs invalid: no messages until a change or publish_all.

Test Plan:
- Reset, all in_*_v=0, out_r=1, 20 cycles -> out_v stays 0, out_seq=0, coalesced_cnt=0.
- Cycle t: sym2 bid 1000 valid, ask 1010 valid; out_r=1 -> at t+2: out_v=1, sym=2, bid=1000, ask=1010, spread=10, crossed=0, seq=0. Exactly one message.
- out_r=0; sym1 bid=100 until out_v (held, bid=100); then apply bid=101, bid=102 on consecutive cycles -> coalesced_cnt=1. With out_r=1: messages sym1 bid=100 seq0, then sym1 bid=102 seq1. No 101 message.
- All 4 symbols change in one cycle, out_r=1 -> back-to-back messages sym 0,1,2,3, seq 0..3. Then sym3 and sym0 change together -> sym0 (seq4), then sym3 (seq5).
- sym0 bid=1010, ask=1010 -> crossed=1, spread=0, crossed_sticky=1. Bid then drops to 1000 -> crossed=0, spread=10, crossed_sticky stays 1.
- Assert rstn mid-stream with out_v=1, out_r=0 -> out_v=0 immediately, pending cleared. Release, pulse publish_all -> 4 messages sym 0..3, seq 0..3.
